// File: rtl/csr_pkg.sv
// Shared constants and types for the M-mode CSR file and trap sequencer.
package csr_pkg;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  localparam logic [3:0] EXC_INSTR_MISALIGN = 4'd0;
  localparam logic [3:0] EXC_ILLEGAL_INSTR  = 4'd2;
  localparam logic [3:0] EXC_BREAKPOINT     = 4'd3;
  localparam logic [3:0] EXC_LOAD_MISALIGN  = 4'd4;
  localparam logic [3:0] EXC_STORE_MISALIGN = 4'd6;
  localparam logic [3:0] EXC_ECALL_M        = 4'd11;
  localparam logic [3:0] IRQ_SW    = 4'd3;
  localparam logic [3:0] IRQ_TIMER = 4'd7;
  localparam logic [3:0] IRQ_EXT   = 4'd11;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  typedef enum logic [1:0] {OP_NOP = 2'b00, OP_RW = 2'b01, OP_RS = 2'b10, OP_RC = 2'b11} csr_op_e;
  typedef enum logic {IDLE = 1'b0, REDIRECT = 1'b1} trap_state_e;

  function automatic logic csr_read_only(input logic [11:0] addr);
    return (addr[11:10] == 2'b11) || (addr == CSR_MIP);
  endfunction
endpackage

// File: rtl/csr_counter64.sv
// 64-bit counter built from two 32-bit halves; a half write beats the increment
// for that half and suppresses any carry into the other half.
module csr_counter64 (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);
  logic [31:0] lo, hi;
  logic        carry;

  assign carry = inc & (&lo) & ~wr_lo;
  assign count = {hi, lo};

  always_ff @(posedge clk) begin
    if (reset) begin
      lo <= '0;
      hi <= '0;
    end else begin
      lo <= wr_lo ? wdata : lo + {31'b0, inc};
      hi <= wr_hi ? wdata : hi + {31'b0, carry};
    end
  end
endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with trap/mret sequencer and registered fetch redirect.
// Optional 64-bit mcycle/minstret counters under CSR_COUNTERS_EN.
module csr_trap_unit
  import csr_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0,
  parameter bit              VECTORED    = 1'b1,
  parameter int unsigned     HART_ID     = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            csr_en,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            illegal_csr,
  input  logic            exc_valid,
  input  logic [3:0]      exc_cause,
  input  logic [XLEN-1:0] exc_tval,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            mret,
  input  logic            irq_ext,
  input  logic            irq_sw,
  input  logic            irq_timer,
  input  logic            instr_retire,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            csr_stall
);
  trap_state_e     state, state_d;
  csr_op_e         op;
  logic            mst_mie, mst_mpie;
  logic [XLEN-1:0] mie_r, mtvec_r, mscratch_r, mepc_r, mcause_r, mtval_r, redirect_pc_r;
  logic [XLEN-1:0] mstatus_v, mip_v, rd_v, wr_v, base, trap_target;
  logic            impl, wr_req, csr_we, idle, take_trap, take_irq, do_mret;
  logic            pend_ext, pend_sw, pend_tim;
  logic [3:0]      irq_code, trap_code;

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle, minstret;
`else
  logic unused_retire;
  assign unused_retire = instr_retire;
`endif

  assign op = csr_op_e'(csr_op);

  always_comb begin
    mstatus_v               = '0;
    mstatus_v[12:11]        = 2'b11;
    mstatus_v[MSTATUS_MPIE] = mst_mpie;
    mstatus_v[MSTATUS_MIE]  = mst_mie;
    mip_v                   = '0;
    mip_v[IRQ_EXT]          = irq_ext;
    mip_v[IRQ_SW]           = irq_sw;
    mip_v[IRQ_TIMER]        = irq_timer;
  end

  always_comb begin
    impl = 1'b1;
    rd_v = '0;
    case (csr_addr)
      CSR_MSTATUS:  rd_v = mstatus_v;
      CSR_MIE:      rd_v = mie_r;
      CSR_MTVEC:    rd_v = mtvec_r;
      CSR_MSCRATCH: rd_v = mscratch_r;
      CSR_MEPC:     rd_v = mepc_r;
      CSR_MCAUSE:   rd_v = mcause_r;
      CSR_MTVAL:    rd_v = mtval_r;
      CSR_MIP:      rd_v = mip_v;
      CSR_MHARTID:  rd_v = XLEN'(HART_ID);
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE,    CSR_CYCLE:    rd_v = XLEN'(mcycle[31:0]);
      CSR_MCYCLEH,   CSR_CYCLEH:   rd_v = XLEN'(mcycle[63:32]);
      CSR_MINSTRET,  CSR_INSTRET:  rd_v = XLEN'(minstret[31:0]);
      CSR_MINSTRETH, CSR_INSTRETH: rd_v = XLEN'(minstret[63:32]);
`endif
      default:      impl = 1'b0;
    endcase
  end

  // RS/RC with a zero operand is a pure read and never counts as a write.
  always_comb begin
    wr_v = rd_v;
    case (op)
      OP_RW:   wr_v = csr_wdata;
      OP_RS:   wr_v = rd_v | csr_wdata;
      OP_RC:   wr_v = rd_v & ~csr_wdata;
      default: wr_v = rd_v;
    endcase
    wr_req = (op == OP_RW) || ((op != OP_NOP) && (csr_wdata != '0));
  end

  assign csr_rdata   = rd_v;
  assign illegal_csr = csr_en & (~impl | (wr_req & csr_read_only(csr_addr)));

  always_comb begin
    pend_ext  = mst_mie & mie_r[IRQ_EXT]   & irq_ext;
    pend_sw   = mst_mie & mie_r[IRQ_SW]    & irq_sw;
    pend_tim  = mst_mie & mie_r[IRQ_TIMER] & irq_timer;
    take_irq  = pend_ext | pend_sw | pend_tim;
    irq_code  = pend_ext ? IRQ_EXT : (pend_sw ? IRQ_SW : IRQ_TIMER);
    idle      = (state == IDLE);
    take_trap = idle & (exc_valid | take_irq);
    do_mret   = idle & mret & ~take_trap;
    csr_we    = idle & csr_en & wr_req & impl & ~csr_read_only(csr_addr) & ~take_trap & ~do_mret;
    trap_code = exc_valid ? exc_cause : irq_code;
    base      = {mtvec_r[XLEN-1:2], 2'b00};
    trap_target = (!exc_valid && VECTORED && mtvec_r[1:0] == 2'b01)
                ? base + (XLEN'(trap_code) << 2) : base;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:     if (take_trap || do_mret) state_d = REDIRECT;
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      redirect_pc_r <= '0;
      mst_mie       <= 1'b0;
      mst_mpie      <= 1'b0;
      mie_r         <= '0;
      mtvec_r       <= MTVEC_RESET;
      mscratch_r    <= '0;
      mepc_r        <= '0;
      mcause_r      <= '0;
      mtval_r       <= '0;
    end else begin
      state <= state_d;
      if (take_trap) begin
        mepc_r        <= {trap_pc[XLEN-1:2], 2'b00};
        mcause_r      <= {~exc_valid, {(XLEN-5){1'b0}}, trap_code};
        mtval_r       <= exc_valid ? exc_tval : '0;
        mst_mpie      <= mst_mie;
        mst_mie       <= 1'b0;
        redirect_pc_r <= trap_target;
      end else if (do_mret) begin
        mst_mie       <= mst_mpie;
        mst_mpie      <= 1'b1;
        redirect_pc_r <= mepc_r;
      end else if (csr_we) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            mst_mie  <= wr_v[MSTATUS_MIE];
            mst_mpie <= wr_v[MSTATUS_MPIE];
          end
          CSR_MIE:      mie_r      <= wr_v;
          CSR_MTVEC:    mtvec_r    <= VECTORED ? wr_v : {wr_v[XLEN-1:2], 2'b00};
          CSR_MSCRATCH: mscratch_r <= wr_v;
          CSR_MEPC:     mepc_r     <= {wr_v[XLEN-1:2], 2'b00};
          CSR_MCAUSE:   mcause_r   <= wr_v;
          CSR_MTVAL:    mtval_r    <= wr_v;
          default: ;
        endcase
      end
    end
  end

  assign redirect_valid = (state == REDIRECT);
  assign csr_stall      = (state == REDIRECT);
  assign redirect_pc    = redirect_pc_r;

`ifdef CSR_COUNTERS_EN
  csr_counter64 u_mcycle (
    .clk   (clk),
    .reset (reset),
    .inc   (1'b1),
    .wr_lo (csr_we && csr_addr == CSR_MCYCLE),
    .wr_hi (csr_we && csr_addr == CSR_MCYCLEH),
    .wdata (wr_v[31:0]),
    .count (mcycle)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .reset (reset),
    .inc   (instr_retire),
    .wr_lo (csr_we && csr_addr == CSR_MINSTRET),
    .wr_hi (csr_we && csr_addr == CSR_MINSTRETH),
    .wdata (wr_v[31:0]),
    .count (minstret)
  );
`endif
endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed scoreboard bench for csr_trap_unit (MTVEC_RESET=0x100, vectored).
module tb_csr_trap_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        csr_en = 1'b0;
  logic [1:0]  csr_op = 2'b00;
  logic [11:0] csr_addr = '0;
  logic [31:0] csr_wdata = '0;
  logic [31:0] csr_rdata;
  logic        illegal_csr;
  logic        exc_valid = 1'b0;
  logic [3:0]  exc_cause = '0;
  logic [31:0] exc_tval = '0;
  logic [31:0] trap_pc = '0;
  logic        mret = 1'b0;
  logic        irq_ext = 1'b0, irq_sw = 1'b0, irq_timer = 1'b0;
  logic        instr_retire = 1'b0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        csr_stall;

  int checks = 0;
  int errors = 0;

  typedef struct {string tag; logic [31:0] val;} exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  csr_trap_unit #(
    .XLEN(32), .MTVEC_RESET(32'h100), .VECTORED(1'b1), .HART_ID(0)
  ) dut (
    .clk(clk), .reset(reset), .csr_en(csr_en), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .illegal_csr(illegal_csr),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tval(exc_tval), .trap_pc(trap_pc),
    .mret(mret), .irq_ext(irq_ext), .irq_sw(irq_sw), .irq_timer(irq_timer),
    .instr_retire(instr_retire), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .csr_stall(csr_stall)
  );

  function automatic void push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endfunction

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed %h", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic idle_in();
    csr_en = 1'b0; csr_op = 2'b00; csr_wdata = '0;
    exc_valid = 1'b0; mret = 1'b0;
  endtask

  // CSRRS with a zero operand: pure read, checks rdata and illegal flag.
  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] v, input logic ill);
    @(negedge clk); idle_in();
    csr_en = 1'b1; csr_op = 2'b10; csr_addr = a;
    push(tag, v); push({tag, "_ill"}, {31'b0, ill});
    #1; chk(csr_rdata); chk({31'b0, illegal_csr});
  endtask

  task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    @(negedge clk); idle_in();
    csr_en = 1'b1; csr_op = op; csr_addr = a; csr_wdata = d;
  endtask

  task automatic wr_ill(input string tag, input logic [1:0] op, input logic [11:0] a,
                        input logic [31:0] d, input logic ill);
    wr(op, a, d);
    push(tag, {31'b0, ill});
    #1; chk({31'b0, illegal_csr});
  endtask

  task automatic exc(input logic [3:0] cause, input logic [31:0] tval, input logic [31:0] pc);
    @(negedge clk); idle_in();
    exc_valid = 1'b1; exc_cause = cause; exc_tval = tval; trap_pc = pc;
  endtask

  task automatic do_mret();
    @(negedge clk); idle_in();
    mret = 1'b1;
  endtask

  // Cycle after the event: one-cycle redirect, then back to IDLE.
  task automatic expect_redirect(input string tag, input logic [31:0] pc);
    @(negedge clk); idle_in();
    push({tag, "_vld"}, 32'd1); push({tag, "_stall"}, 32'd1); push({tag, "_pc"}, pc);
    #1; chk({31'b0, redirect_valid}); chk({31'b0, csr_stall}); chk(redirect_pc);
    @(negedge clk);
    push({tag, "_vld_drop"}, 32'd0);
    #1; chk({31'b0, redirect_valid});
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    push("rst_vld", 0); push("rst_stall", 0); push("rst_pc", 0);
    #1; chk({31'b0, redirect_valid}); chk({31'b0, csr_stall}); chk(redirect_pc);
    reset = 1'b0;

    rd("mtvec_rst", 12'h305, 32'h100, 1'b0);
    rd("mstatus_rst", 12'h300, 32'h0000_1800, 1'b0);
    rd("mscratch_rst", 12'h340, 32'h0, 1'b0);

    wr(2'b01, 12'h340, 32'hA5A5_0000);
    wr(2'b10, 12'h340, 32'h0000_00FF);
    wr(2'b11, 12'h340, 32'hA500_0000);
    rd("mscratch_rsrc", 12'h340, 32'h00A5_00FF, 1'b0);
    rd("mhartid_rs0", 12'hF14, 32'h0, 1'b0);
    wr_ill("mhartid_rw_ill", 2'b01, 12'hF14, 32'h5, 1'b1);
    rd("mhartid_keep", 12'hF14, 32'h0, 1'b0);
    rd("unimpl", 12'h123, 32'h0, 1'b1);
    wr_ill("mip_rw_ill", 2'b01, 12'h344, 32'h8, 1'b1);
    rd("mepc_low", 12'h341, 32'h0, 1'b0);
    wr(2'b01, 12'h341, 32'h0000_1237);
    rd("mepc_mask", 12'h341, 32'h0000_1234, 1'b0);

    // Synchronous exception then mret
    wr(2'b01, 12'h305, 32'h200);
    wr(2'b10, 12'h300, 32'h8);
    rd("mstatus_mie1", 12'h300, 32'h0000_1808, 1'b0);
    exc(4'd11, 32'hDEAD, 32'h44);
    expect_redirect("exc11", 32'h200);
    rd("exc_mepc", 12'h341, 32'h44, 1'b0);
    rd("exc_mcause", 12'h342, 32'hB, 1'b0);
    rd("exc_mtval", 12'h343, 32'hDEAD, 1'b0);
    rd("exc_mstatus", 12'h300, 32'h0000_1880, 1'b0);
    do_mret();
    expect_redirect("mret1", 32'h44);
    rd("mret_mstatus", 12'h300, 32'h0000_1888, 1'b0);

    // Vectored timer interrupt
    wr(2'b01, 12'h305, 32'h201);
    wr(2'b10, 12'h304, 32'h80);
    @(negedge clk); idle_in(); irq_timer = 1'b1; trap_pc = 32'h80;
    expect_redirect("irq_tim", 32'h21C);
    irq_timer = 1'b0;
    rd("tim_mcause", 12'h342, 32'h8000_0007, 1'b0);
    rd("tim_mtval", 12'h343, 32'h0, 1'b0);
    rd("tim_mepc", 12'h341, 32'h80, 1'b0);
    do_mret();
    expect_redirect("mret2", 32'h80);

    // ext beats timer
    wr(2'b10, 12'h304, 32'h800);
    @(negedge clk); idle_in(); irq_ext = 1'b1; irq_timer = 1'b1; trap_pc = 32'h90;
    expect_redirect("irq_ext", 32'h22C);
    irq_ext = 1'b0; irq_timer = 1'b0;
    rd("ext_mcause", 12'h342, 32'h8000_000B, 1'b0);
    do_mret();
    expect_redirect("mret3", 32'h90);
    irq_sw = 1'b1;
    rd("mip_sw", 12'h344, 32'h8, 1'b0);
    irq_sw = 1'b0;

    // Exception beats pending interrupt and a same-cycle CSR write
    @(negedge clk); idle_in();
    exc_valid = 1'b1; exc_cause = 4'd2; exc_tval = 32'h77; trap_pc = 32'hA0; irq_ext = 1'b1;
    csr_en = 1'b1; csr_op = 2'b01; csr_addr = 12'h340; csr_wdata = 32'h1234;
    // Events during REDIRECT must have no effect.
    @(negedge clk); idle_in(); irq_ext = 1'b0;
    exc_valid = 1'b1; exc_cause = 4'd4; mret = 1'b1;
    csr_en = 1'b1; csr_op = 2'b01; csr_addr = 12'h340; csr_wdata = 32'h5555;
    push("prio_vld", 1); push("prio_pc", 32'h200);
    #1; chk({31'b0, redirect_valid}); chk(redirect_pc);
    @(negedge clk); idle_in();
    push("redir_ignored", 0);
    #1; chk({31'b0, redirect_valid});
    rd("prio_mscratch", 12'h340, 32'h00A5_00FF, 1'b0);
    rd("prio_mcause", 12'h342, 32'h2, 1'b0);
    rd("prio_mtval", 12'h343, 32'h77, 1'b0);

    // Reset during REDIRECT
    exc(4'd0, 32'h0, 32'hB0);
    @(negedge clk); idle_in(); reset = 1'b1;
    push("rr_vld_before", 1);
    #1; chk({31'b0, redirect_valid});
    @(negedge clk);
    push("rr_vld", 0); push("rr_stall", 0); push("rr_pc", 0);
    #1; chk({31'b0, redirect_valid}); chk({31'b0, csr_stall}); chk(redirect_pc);
    reset = 1'b0;
    rd("rr_mtvec", 12'h305, 32'h100, 1'b0);
    rd("rr_mstatus", 12'h300, 32'h0000_1800, 1'b0);

`ifdef CSR_COUNTERS_EN
    wr(2'b01, 12'hB80, 32'h0);
    wr(2'b01, 12'hB00, 32'hFFFF_FFFF);
    @(negedge clk); idle_in();
    rd("mcycle_wrap", 12'hB00, 32'h0, 1'b0);
    rd("mcycleh_carry", 12'hB80, 32'h1, 1'b0);
    rd("cycleh_shadow", 12'hC80, 32'h1, 1'b0);
`else
    rd("mcycle_unimpl", 12'hB00, 32'h0, 1'b1);
    rd("cycle_unimpl", 12'hC00, 32'h0, 1'b1);
`endif

    @(negedge clk); idle_in();
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $error("FAIL scoreboard_leftover observed %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
